// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : Fetch-stage program counter. Provides a configurable reset
//                vector and increment, stall hold, branch/jump redirect with
//                a one-entry pending-redirect buffer for redirects that arrive
//                during a stall, exception vectoring and a misalignment flag.
//                Optional PC history ring enabled by the PC_HISTORY_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_unit #(
  parameter int                 WIDTH        = 32,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = WIDTH'(32'h00003000),
  parameter logic [WIDTH-1:0]   EXC_VECTOR   = WIDTH'(32'h00004180),
  parameter int                 INC          = 4,
  parameter int                 HIST_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic                          br_valid,
  input  logic [WIDTH-1:0]              br_target,
  input  logic                          exc_valid,
  output logic [WIDTH-1:0]              pc,
  output logic                          pc_valid,
  output logic                          pend,
  output logic                          misalign,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [WIDTH-1:0]              hist_data
);

  localparam int               HIST_AW = $clog2(HIST_DEPTH);
  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);

  // --------------------------------------------------------------------------
  // Core PC state
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] pc_q,          pc_d;
  logic             pc_valid_q,    pc_valid_d;
  logic             pend_q,        pend_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;

  // Next-PC selection: exception > stall (buffer redirect) > live redirect >
  // buffered redirect > sequential increment.
  always_comb begin
    pc_d          = pc_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    pc_valid_d    = 1'b1;

    if (exc_valid) begin
      // Vectoring is never blocked by stall; any buffered redirect is dropped.
      pc_d   = EXC_VECTOR;
      pend_d = 1'b0;
    end else if (stall) begin
      // Hold the PC; remember the newest redirect seen while stalled.
      if (br_valid) begin
        pend_d        = 1'b1;
        pend_target_d = br_target;
      end
    end else if (br_valid) begin
      // A live redirect is newer than anything buffered, so it wins.
      pc_d   = br_target;
      pend_d = 1'b0;
    end else if (pend_q) begin
      pc_d   = pend_target_q;
      pend_d = 1'b0;
    end else begin
      // Wraps modulo 2^WIDTH by truncation.
      pc_d = pc_q + INC_W;
    end
  end

  // PC registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_VECTOR;
      pc_valid_q    <= 1'b0;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      pc_valid_q    <= pc_valid_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc       = pc_q;
  assign pc_valid = pc_valid_q;
  assign pend     = pend_q;
  // Target addresses are loaded unchecked; the consumer decides whether to trap.
  assign misalign = (pc_q[1:0] != 2'b00);

`ifdef PC_HISTORY_EN
  // --------------------------------------------------------------------------
  // PC history ring: the outgoing PC is recorded whenever the PC changes value.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]   hist_q [HIST_DEPTH];
  logic [WIDTH-1:0]   hist_d [HIST_DEPTH];
  logic [HIST_AW-1:0] wptr_q, wptr_d;
  logic [HIST_AW-1:0] rd_ptr;

  // Ring write: record old PC at the write pointer and advance (wraps naturally).
  always_comb begin
    hist_d = hist_q;
    wptr_d = wptr_q;
    if (pc_d != pc_q) begin
      hist_d[wptr_q] = pc_q;
      wptr_d         = wptr_q + HIST_AW'(1);
    end
  end

  // History registers, cleared by reset (reset itself is never recorded).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_q[i] <= '0;
      end
      wptr_q <= '0;
    end else begin
      hist_q <= hist_d;
      wptr_q <= wptr_d;
    end
  end

  // Index 0 is the most recent previous PC; arithmetic wraps modulo HIST_DEPTH.
  assign rd_ptr    = wptr_q - HIST_AW'(1) - hist_idx;
  assign hist_data = hist_q[rd_ptr];
`else
  // No history storage; the read index is intentionally ignored.
  logic unused_hist_idx;
  assign unused_hist_idx = ^hist_idx;
  assign hist_data       = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pc_unit
//  Description : Directed self-checking testbench for pc_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  localparam int WIDTH      = 32;
  localparam int HIST_DEPTH = 8;

  logic             clk;
  logic             rst;
  logic             stall;
  logic             br_valid;
  logic [WIDTH-1:0] br_target;
  logic             exc_valid;
  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic             pend;
  logic             misalign;
  logic [2:0]       hist_idx;
  logic [WIDTH-1:0] hist_data;

  int checks;
  int errors;

  pc_unit #(
    .WIDTH        (WIDTH),
    .RESET_VECTOR (32'h00003000),
    .EXC_VECTOR   (32'h00004180),
    .INC          (4),
    .HIST_DEPTH   (HIST_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_target (br_target),
    .exc_valid (exc_valid),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .pend      (pend),
    .misalign  (misalign),
    .hist_idx  (hist_idx),
    .hist_data (hist_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle before sampling / changing inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall     = 1'b0;
    br_valid  = 1'b0;
    br_target = '0;
    exc_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    checks++; if (pc !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h3000); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pc_valid); end
    checks++; if (pend !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b expected 0", pend); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign); end
    rst = 1'b0;
    step();
    checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL run_pc1: got %h expected %h", pc, 32'h3004); end
    checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL run_valid: got %b expected 1", pc_valid); end
    step();
    checks++; if (pc !== 32'h3008) begin errors++; $display("FAIL run_pc2: got %h expected %h", pc, 32'h3008); end
    step();
    checks++; if (pc !== 32'h300C) begin errors++; $display("FAIL run_pc3: got %h expected %h", pc, 32'h300C); end
    step();
    checks++; if (pc !== 32'h3010) begin errors++; $display("FAIL run_pc4: got %h expected %h", pc, 32'h3010); end
  endtask

  task automatic test_stall_redirect();
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h3100;
    step();
    checks++; if (pc !== 32'h3010) begin errors++; $display("FAIL stall_hold1: got %h expected %h", pc, 32'h3010); end
    checks++; if (pend !== 1'b1) begin errors++; $display("FAIL stall_pend1: got %b expected 1", pend); end
    br_valid = 1'b0; br_target = 32'h0;
    step();
    step();
    checks++; if (pc !== 32'h3010) begin errors++; $display("FAIL stall_hold3: got %h expected %h", pc, 32'h3010); end
    checks++; if (pend !== 1'b1) begin errors++; $display("FAIL stall_pend3: got %b expected 1", pend); end
    stall = 1'b0;
    step();
    checks++; if (pc !== 32'h3100) begin errors++; $display("FAIL pend_apply: got %h expected %h", pc, 32'h3100); end
    checks++; if (pend !== 1'b0) begin errors++; $display("FAIL pend_clear: got %b expected 0", pend); end
    step();
    checks++; if (pc !== 32'h3104) begin errors++; $display("FAIL pend_after: got %h expected %h", pc, 32'h3104); end
  endtask

  task automatic test_overwrite_live();
    // Newer buffered redirect overwrites older one.
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h3200;
    step();
    br_target = 32'h3300;
    step();
    checks++; if (pc !== 32'h3104) begin errors++; $display("FAIL ovw_hold: got %h expected %h", pc, 32'h3104); end
    stall = 1'b0; br_valid = 1'b0;
    step();
    checks++; if (pc !== 32'h3300) begin errors++; $display("FAIL ovw_apply: got %h expected %h", pc, 32'h3300); end
    // Live redirect on unstall edge beats the buffered target.
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h3200;
    step();
    br_target = 32'h3300;
    step();
    stall = 1'b0; br_valid = 1'b1; br_target = 32'h3400;
    step();
    checks++; if (pc !== 32'h3400) begin errors++; $display("FAIL live_wins: got %h expected %h", pc, 32'h3400); end
    checks++; if (pend !== 1'b0) begin errors++; $display("FAIL live_pend: got %b expected 0", pend); end
    br_valid = 1'b0;
    step();
    checks++; if (pc !== 32'h3404) begin errors++; $display("FAIL live_after: got %h expected %h", pc, 32'h3404); end
  endtask

  task automatic test_exception();
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h3500;
    step();
    checks++; if (pend !== 1'b1) begin errors++; $display("FAIL exc_prepend: got %b expected 1", pend); end
    exc_valid = 1'b1; br_target = 32'h3600;
    step();
    checks++; if (pc !== 32'h4180) begin errors++; $display("FAIL exc_vector: got %h expected %h", pc, 32'h4180); end
    checks++; if (pend !== 1'b0) begin errors++; $display("FAIL exc_pend: got %b expected 0", pend); end
    exc_valid = 1'b0; br_valid = 1'b0;
    step();
    checks++; if (pc !== 32'h4180) begin errors++; $display("FAIL exc_hold: got %h expected %h", pc, 32'h4180); end
    stall = 1'b0;
    step();
    checks++; if (pc !== 32'h4184) begin errors++; $display("FAIL exc_unstall: got %h expected %h", pc, 32'h4184); end
    step();
    checks++; if (pc !== 32'h4188) begin errors++; $display("FAIL exc_next: got %h expected %h", pc, 32'h4188); end
  endtask

  task automatic test_wrap_misalign();
    br_valid = 1'b1; br_target = 32'hFFFFFFFC;
    step();
    checks++; if (pc !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_load: got %h expected %h", pc, 32'hFFFFFFFC); end
    br_valid = 1'b0;
    step();
    checks++; if (pc !== 32'h00000000) begin errors++; $display("FAIL wrap_zero: got %h expected %h", pc, 32'h0); end
    checks++; if (pend !== 1'b0 || pc_valid !== 1'b1) begin errors++; $display("FAIL wrap_side: got pend=%b valid=%b expected pend=0 valid=1", pend, pc_valid); end
    step();
    checks++; if (pc !== 32'h00000004) begin errors++; $display("FAIL wrap_next: got %h expected %h", pc, 32'h4); end
    br_valid = 1'b1; br_target = 32'h3002;
    step();
    checks++; if (pc !== 32'h3002 || misalign !== 1'b1) begin errors++; $display("FAIL misalign_set: got pc=%h mis=%b expected pc=3002 mis=1", pc, misalign); end
    br_valid = 1'b0;
    step();
    checks++; if (pc !== 32'h3006 || misalign !== 1'b1) begin errors++; $display("FAIL misalign_inc: got pc=%h mis=%b expected pc=3006 mis=1", pc, misalign); end
    br_valid = 1'b1; br_target = 32'h3008;
    step();
    checks++; if (pc !== 32'h3008 || misalign !== 1'b0) begin errors++; $display("FAIL misalign_clr: got pc=%h mis=%b expected pc=3008 mis=0", pc, misalign); end
    br_valid = 1'b0;
  endtask

  task automatic test_reset_override();
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h3700;
    step();
    checks++; if (pend !== 1'b1) begin errors++; $display("FAIL rstov_pre: got %b expected 1", pend); end
    rst = 1'b1; exc_valid = 1'b1;
    step();
    checks++; if (pc !== 32'h3000 || pend !== 1'b0 || pc_valid !== 1'b0) begin errors++; $display("FAIL rst_override: got pc=%h pend=%b valid=%b expected 3000/0/0", pc, pend, pc_valid); end
    idle_inputs();
    step();
    rst = 1'b0;
    step();
    checks++; if (pc !== 32'h3004) begin errors++; $display("FAIL rstov_post: got %h expected %h (stale target leaked?)", pc, 32'h3004); end
  endtask

  task automatic test_history();
    rst = 1'b1;
    idle_inputs();
    hist_idx = 3'd0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    checks++; if (pc !== 32'h3028) begin errors++; $display("FAIL hist_pc: got %h expected %h", pc, 32'h3028); end
`ifdef PC_HISTORY_EN
    hist_idx = 3'd0; #1;
    checks++; if (hist_data !== 32'h3024) begin errors++; $display("FAIL hist_idx0: got %h expected %h", hist_data, 32'h3024); end
    hist_idx = 3'd7; #1;
    checks++; if (hist_data !== 32'h3008) begin errors++; $display("FAIL hist_idx7: got %h expected %h", hist_data, 32'h3008); end
    hist_idx = 3'd3; #1;
    checks++; if (hist_data !== 32'h3018) begin errors++; $display("FAIL hist_idx3: got %h expected %h", hist_data, 32'h3018); end
    stall = 1'b1;
    step();
    step();
    hist_idx = 3'd0; #1;
    checks++; if (hist_data !== 32'h3024) begin errors++; $display("FAIL hist_stall: got %h expected %h", hist_data, 32'h3024); end
    stall = 1'b0;
    step();
    #1;
    checks++; if (hist_data !== 32'h3028) begin errors++; $display("FAIL hist_resume: got %h expected %h", hist_data, 32'h3028); end
`else
    hist_idx = 3'd0; #1;
    checks++; if (hist_data !== 32'h0) begin errors++; $display("FAIL hist_off0: got %h expected 0", hist_data); end
    hist_idx = 3'd7; #1;
    checks++; if (hist_data !== 32'h0) begin errors++; $display("FAIL hist_off7: got %h expected 0", hist_data); end
`endif
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    hist_idx = 3'd0;
    rst      = 1'b1;
    idle_inputs();
    test_reset();
    test_stall_redirect();
    test_overwrite_live();
    test_exception();
    test_wrap_misalign();
    test_reset_override();
    test_history();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
